// File: rtl/mips_cp0_pkg.sv
// Shared definitions for the coprocessor0 / exception sequencing slice of the mips_s core:
// sequencer state encoding, control decode, handler vector and exception codes.
package mips_cp0_pkg;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h8000_0180;
  localparam int          DRAIN_MAX_DEFAULT    = 15;
  localparam int          CNT_WIDTH_DEFAULT    = 16;

  // Cause.ExcCode values, kept identical to the encoding used by coprocessor0.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_COMMIT     = 3'd2,
    ST_EXC_REDIR  = 3'd3,
    ST_ERET_REDIR = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic activeexception;
    logic rfe;
    logic stall;
    logic flush;
    logic redirect_valid;
  } seq_ctrl_t;

  // Moore decode of the per-state control strobes.
  function automatic seq_ctrl_t decode_ctrl(input seq_state_e s);
    seq_ctrl_t c;
    c = '0;
    case (s)
      ST_DRAIN: begin
        c.stall = 1'b1;
        c.flush = 1'b1;
      end
      ST_COMMIT: begin
        c.activeexception = 1'b1;
        c.stall           = 1'b1;
        c.flush           = 1'b1;
      end
      ST_EXC_REDIR: begin
        c.redirect_valid = 1'b1;
        c.flush          = 1'b1;
      end
      ST_ERET_REDIR: begin
        c.redirect_valid = 1'b1;
        c.rfe            = 1'b1;
        c.flush          = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exception_sequencer_drain_timer.sv
// Bounded wait counter for the DRAIN state: counts enabled cycles since the last clear
// and flags the cycle that is the MAX-th enabled one. Saturates instead of wrapping.
module drain_timer #(
  parameter int MAX = 15,
  localparam int W  = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of enabled cycles already completed, so the current one is count+1.
  assign expired = enable && (count >= W'(MAX - 1));

endmodule

// File: rtl/exception_sequencer.sv
// Decides when a pending exception is taken, drains in-flight memory accesses, pulses
// activeexception/rfe into coprocessor0 and redirects fetch to the handler or to EPC.
module exception_sequencer
  import mips_cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter int          DRAIN_MAX    = DRAIN_MAX_DEFAULT,
  parameter int          CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pendingexception,
  input  logic                 eret,
  input  logic [31:0]          epc,
  input  logic                 mem_busy,
  output logic                 activeexception,
  output logic                 rfe,
  output logic                 stall,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 in_handler,
  output logic                 drain_timeout,
  output logic [CNT_WIDTH-1:0] exc_count
);

  seq_state_e state_q;
  seq_state_e state_d;
  seq_ctrl_t  ctrl_d;
  logic       timeout_hit;
  logic       drain_expired;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  drain_timer #(
    .MAX(DRAIN_MAX)
  ) u_drain_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != ST_DRAIN),
    .enable (state_q == ST_DRAIN),
    .expired(drain_expired)
  );

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An exception raised alongside ERET wins; the ERET is simply dropped.
        if (pendingexception) begin
          state_d = mem_busy ? ST_DRAIN : ST_COMMIT;
        end else if (eret) begin
          state_d = ST_ERET_REDIR;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy) begin
          state_d = ST_COMMIT;
        end else if (drain_expired) begin
          state_d     = ST_COMMIT;
          timeout_hit = 1'b1;
        end
      end
      ST_COMMIT:     state_d = ST_EXC_REDIR;
      ST_EXC_REDIR:  state_d = ST_IDLE;
      ST_ERET_REDIR: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  assign ctrl_d = decode_ctrl(state_d);

  // Output registers are loaded from the next-state decode so every output is a flop
  // whose value matches the state the machine is entering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      activeexception <= 1'b0;
      rfe             <= 1'b0;
      stall           <= 1'b0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      in_handler      <= 1'b0;
      drain_timeout   <= 1'b0;
      exc_count       <= '0;
    end else begin
      state_q         <= state_d;
      activeexception <= ctrl_d.activeexception;
      rfe             <= ctrl_d.rfe;
      stall           <= ctrl_d.stall;
      flush           <= ctrl_d.flush;
      redirect_valid  <= ctrl_d.redirect_valid;
      // ERET_REDIR is only entered from IDLE, so epc is captured on exactly that transition.
      case (state_d)
        ST_EXC_REDIR:  redirect_pc <= HANDLER_ADDR;
        ST_ERET_REDIR: redirect_pc <= epc;
        default:       redirect_pc <= '0;
      endcase
      if (state_d == ST_EXC_REDIR) begin
        in_handler <= 1'b1;
      end else if (state_d == ST_ERET_REDIR) begin
        in_handler <= 1'b0;
      end
      if (timeout_hit) begin
        drain_timeout <= 1'b1;
      end
      if (state_d == ST_COMMIT) begin
        exc_count <= sat_inc(exc_count);
      end
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: a cycle-by-cycle vector table plus hand-written
// sequences for the drain timeout and the counter saturation.
module tb_exception_sequencer;

  localparam logic [31:0] H = 32'h8000_0180;
  localparam logic [31:0] E = 32'h0040_0020;

  logic        clk;
  logic        reset;
  logic        pendingexception;
  logic        eret;
  logic [31:0] epc;
  logic        mem_busy;
  logic        activeexception, rfe, stall, flush, redirect_valid, in_handler, drain_timeout;
  logic [31:0] redirect_pc;
  logic [15:0] exc_count;

  logic        s_act, s_rfe, s_stall, s_flush, s_rv, s_inh, s_dto;
  logic [31:0] s_rpc;
  logic [1:0]  s_cnt;

  int vectors;
  int miscompares;

  exception_sequencer dut (
    .clk(clk), .reset(reset), .pendingexception(pendingexception), .eret(eret),
    .epc(epc), .mem_busy(mem_busy), .activeexception(activeexception), .rfe(rfe),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .in_handler(in_handler), .drain_timeout(drain_timeout),
    .exc_count(exc_count)
  );

  // Narrow counter instance so saturation is reachable in a few exceptions.
  exception_sequencer #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .pendingexception(pendingexception), .eret(eret),
    .epc(epc), .mem_busy(mem_busy), .activeexception(s_act), .rfe(s_rfe),
    .stall(s_stall), .flush(s_flush), .redirect_valid(s_rv),
    .redirect_pc(s_rpc), .in_handler(s_inh), .drain_timeout(s_dto),
    .exc_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, pend, er, busy;
    logic [31:0] epc;
    logic        act, rfe, stall, flush, rv;
    logic [31:0] rpc;
    logic        inh, dto;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, pend, er, busy, input logic [31:0] e,
                              input logic a, r, st, fl, rv, input logic [31:0] rpc,
                              input logic inh, dto, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.pend = pend; v.er = er; v.busy = busy; v.epc = e;
    v.act = a; v.rfe = r; v.stall = st; v.flush = fl; v.rv = rv; v.rpc = rpc;
    v.inh = inh; v.dto = dto; v.cnt = cnt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return {9'd0, activeexception, rfe, stall, flush, redirect_valid, redirect_pc,
            in_handler, drain_timeout, exc_count};
  endfunction

  vec_t vecs[27];

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; pendingexception = 1'b0; eret = 1'b0; epc = '0; mem_busy = 1'b0;

    //              rst p e b epc   act rfe st fl rv rpc  inh dto cnt
    vecs[0]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 0,   0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, H,   1, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 1);
    vecs[5]  = mk(0, 0, 1, 0, E,   0, 1, 0, 1, 1, E,   0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 1);
    vecs[7]  = mk(0, 1, 1, 0, E,   1, 0, 1, 1, 0, 0,   0, 0, 2);
    vecs[8]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, H,   1, 0, 2);
    vecs[9]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 2);
    vecs[10] = mk(0, 1, 0, 1, 0,   0, 0, 1, 1, 0, 0,   1, 0, 2);
    vecs[11] = mk(0, 0, 0, 1, 0,   0, 0, 1, 1, 0, 0,   1, 0, 2);
    vecs[12] = mk(0, 0, 0, 1, 0,   0, 0, 1, 1, 0, 0,   1, 0, 2);
    vecs[13] = mk(0, 0, 0, 1, 0,   0, 0, 1, 1, 0, 0,   1, 0, 2);
    vecs[14] = mk(0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0,   1, 0, 3);
    vecs[15] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, H,   1, 0, 3);
    vecs[16] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 3);
    vecs[17] = mk(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 0,   1, 0, 4);
    vecs[18] = mk(0, 1, 0, 0, 0,   0, 0, 0, 1, 1, H,   1, 0, 4);
    vecs[19] = mk(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 4);
    vecs[20] = mk(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 0,   1, 0, 5);
    vecs[21] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 1, H,   1, 0, 5);
    vecs[22] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 5);
    vecs[23] = mk(0, 1, 0, 1, 0,   0, 0, 1, 1, 0, 0,   1, 0, 5);
    vecs[24] = mk(0, 0, 1, 1, E,   0, 0, 1, 1, 0, 0,   1, 0, 5);
    vecs[25] = mk(1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0);

    for (int i = 0; i < 27; i++) begin
      reset = vecs[i].rst; pendingexception = vecs[i].pend; eret = vecs[i].er;
      mem_busy = vecs[i].busy; epc = vecs[i].epc;
      step();
      expect_val($sformatf("vec%0d", i), pack_out(),
                 {9'd0, vecs[i].act, vecs[i].rfe, vecs[i].stall, vecs[i].flush, vecs[i].rv,
                  vecs[i].rpc, vecs[i].inh, vecs[i].dto, vecs[i].cnt});
    end

    // mem_busy never drops: 15 DRAIN cycles, then a forced commit with sticky timeout.
    pendingexception = 1'b1; mem_busy = 1'b1;
    step();
    pendingexception = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      expect_val($sformatf("drain_cycle%0d", i),
                 {60'd0, stall, flush, activeexception, drain_timeout}, 64'b1100);
      step();
    end
    expect_val("timeout_commit", {60'd0, stall, flush, activeexception, drain_timeout}, 64'b1111);
    mem_busy = 1'b0;
    step();
    expect_val("timeout_redir", {31'd0, redirect_valid, redirect_pc}, {31'd0, 1'b1, H});
    expect_val("timeout_sticky1", {63'd0, drain_timeout}, 64'd1);
    step();
    step();
    expect_val("timeout_sticky2", {63'd0, drain_timeout}, 64'd1);
    reset = 1'b1;
    step();
    expect_val("timeout_reset", pack_out(), 64'd0);
    reset = 1'b0;
    step();

    // Counter saturation: the 2-bit instance must stop at all-ones.
    for (int k = 1; k <= 5; k++) begin
      pendingexception = 1'b1;
      step();
      expect_val($sformatf("sat_cnt%0d", k), {62'd0, s_cnt}, (k > 3) ? 64'd3 : 64'(k));
      expect_val($sformatf("wide_cnt%0d", k), {48'd0, exc_count}, 64'(k));
      pendingexception = 1'b0;
      step();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
